// File: rtl/pixel_stream_pkg.sv
// pixel_stream_pkg: shared types and constants for the pixel frame streamer.
package pixel_stream_pkg;
  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } pix_flags_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic [7:0] PAT_HI = 8'd250;
  localparam logic [7:0] PAT_LO = 8'd20;
  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction
endpackage

// File: rtl/pixel_skid_fifo.sv
// pixel_skid_fifo: 3-deep pixel+flags FIFO with occupancy count, cleared by rst.
module pixel_skid_fifo
  import pixel_stream_pkg::*;
#(
  parameter int DW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [1:0]    count
);
  logic [DW-1:0] mem_q [3];
  logic [DW-1:0] mem_d [3];
  logic [1:0] wr_q, wr_d, rd_q, rd_d, count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d = push ? inc3(wr_q) : wr_q;
    rd_d = pop ? inc3(rd_q) : rd_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      for (int i = 0; i < 3; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
      mem_q <= mem_d;
    end
  end
  assign dout = mem_q[rd_q];
  assign count = count_q;
  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && count_q == 2'd3));
endmodule

// File: rtl/pixel_frame_streamer.sv
// pixel_frame_streamer: reads one frame row-major from a 1-cycle-latency frame buffer and streams it with sof/eol/eof.
// Optional TEST_PATTERN_EN adds an internal striped test-pattern source selected by pattern_sel.
module pixel_frame_streamer
  import pixel_stream_pkg::*;
#(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int W          = 8,
  parameter int ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT),
  parameter int STRIPE_H   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic              pattern_sel,
  output logic              busy,
  output logic              frame_done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [W-1:0]      mem_rd_data,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [W-1:0]      y_data,
  output logic              y_sof,
  output logic              y_eol,
  output logic              y_eof
);
  localparam int N  = IMG_WIDTH * IMG_HEIGHT;
  localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int DW = W + 3;
  state_t state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic inflight_q, inflight_d;
  logic frame_done_q, frame_done_d;
  pix_flags_t rd_flags_q, rd_flags_d;
  logic [1:0] fifo_count;
  logic [DW-1:0] fifo_dout;
  logic [W-1:0] push_data;
  logic issue, pop, at_eol, at_eof, pat_en;
  // Occupancy counts the in-flight read so the FIFO can never overflow.
  assign issue = (state_q == RUN) && (({1'b0, fifo_count} + {2'b0, inflight_q}) < 3'd3);
  assign at_eol = x_q == XW'(IMG_WIDTH - 1);
  assign at_eof = addr_q == ADDR_W'(N - 1);
  assign pop = y_valid & y_ready;
  always_comb begin
    state_d = (state_q == IDLE && start) ? RUN :
              (issue && at_eof) ? DRAIN :
              (state_q == DRAIN && pop && fifo_dout[0]) ? (continuous ? RUN : IDLE) : state_q;
    frame_done_d = state_q == DRAIN && pop && fifo_dout[0];
    inflight_d = issue;
    rd_flags_d = '{sof: addr_q == '0, eol: at_eol, eof: at_eof};
    x_d = !issue ? x_q : at_eol ? '0 : x_q + XW'(1);
    y_d = !(issue && at_eol) ? y_q : at_eof ? '0 : y_q + YW'(1);
    addr_d = !issue ? addr_q : at_eof ? '0 : addr_q + ADDR_W'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      addr_q <= '0;
      inflight_q <= 1'b0;
      frame_done_q <= 1'b0;
      rd_flags_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      addr_q <= addr_d;
      inflight_q <= inflight_d;
      frame_done_q <= frame_done_d;
      rd_flags_q <= rd_flags_d;
    end
  end
`ifdef TEST_PATTERN_EN
  logic pat_q, pat_d;
  logic [W-1:0] pat_pix_q, pat_pix_d;
  always_comb begin
    pat_d = (state_d == RUN && state_q != RUN) ? pattern_sel : pat_q;
    pat_pix_d = (((int'(y_q) / STRIPE_H) % 2) == 0) ? W'(PAT_HI) : W'(PAT_LO);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q <= 1'b0;
      pat_pix_q <= '0;
    end else begin
      pat_q <= pat_d;
      pat_pix_q <= pat_pix_d;
    end
  end
  assign pat_en = pat_q;
  assign push_data = pat_q ? pat_pix_q : mem_rd_data;
`else
  localparam int unused_stripe_h = STRIPE_H;
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
  assign pat_en = 1'b0;
  assign push_data = mem_rd_data;
`endif
  pixel_skid_fifo #(.DW(DW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .pop   (pop),
    .din   ({push_data, rd_flags_q}),
    .dout  (fifo_dout),
    .count (fifo_count)
  );
  assign mem_rd_en = issue & ~pat_en;
  assign mem_addr = addr_q;
  assign busy = state_q != IDLE;
  assign frame_done = frame_done_q;
  assign y_valid = fifo_count != 2'd0;
  assign {y_data, y_sof, y_eol, y_eof} = fifo_dout;
endmodule

// File: tb/tb_pixel_frame_streamer.sv
// tb_pixel_frame_streamer: vector table plus randomized-backpressure scoreboard for pixel_frame_streamer (8x4 frame).
module tb_pixel_frame_streamer;
  localparam int WD = 8;
  localparam int HT = 4;
  localparam int N = WD * HT;
  localparam int AW = $clog2(N);
  logic clk = 1'b0;
  logic rst, start, continuous, pattern_sel, y_ready;
  logic busy, frame_done, mem_rd_en, y_valid, y_sof, y_eol, y_eof;
  logic [AW-1:0] mem_addr;
  logic [7:0] mem_rd_data, y_data;
  int checks = 0;
  int fails = 0;
  int pix, issued, popped, dones;
  logic pat_mode, prev_stall;
  logic [10:0] prev_out;
  typedef struct {
    logic start;
    logic ready;
    logic valid;
    logic [10:0] px;
    logic busy;
    logic done;
    logic chk_rd;
  } vec_t;
  vec_t tbl[36];

  always #5 clk = ~clk;

  pixel_frame_streamer #(.IMG_WIDTH(WD), .IMG_HEIGHT(HT), .W(8), .STRIPE_H(2)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .pattern_sel(pattern_sel),
    .busy(busy), .frame_done(frame_done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
    .y_sof(y_sof), .y_eol(y_eol), .y_eof(y_eof)
  );

  // Frame buffer holds its own address as the pixel value.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= 8'(mem_addr);

  function automatic logic [10:0] expect_px(input int i);
    int k = i % N;
    int row = k / WD;
    logic [7:0] d;
    d = pat_mode ? (((row / 2) % 2 == 0) ? 8'd250 : 8'd20) : 8'(k);
    return {d, k == 0, (k % WD) == WD - 1, k == N - 1};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [10:0] cur = {y_data, y_sof, y_eol, y_eof};
    if (prev_stall) check("stall_hold", {21'b0, y_valid, cur}, {21'b0, 1'b1, prev_out});
    if (pat_mode) check("pat_no_read", {31'b0, mem_rd_en}, 0);
    else if (mem_rd_en) begin
      check("issue_limit", {31'b0, (issued - popped) < 3}, 1);
      issued++;
    end
    if (y_valid && y_ready) begin
      check("pixel", {21'b0, cur}, {21'b0, expect_px(pix)});
      pix++;
      popped++;
    end
    if (frame_done) dones++;
    prev_stall = y_valid && !y_ready;
    prev_out = cur;
    @(posedge clk);
    #1;
    if (rst) begin
      pix = 0;
      issued = 0;
      popped = 0;
      prev_stall = 1'b0;
    end
  endtask

  task automatic clear_model();
    pix = 0;
    issued = 0;
    popped = 0;
    dones = 0;
  endtask

  task automatic start_frame(input int pct);
    y_ready = ($urandom_range(99) < pct);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_idle(input int budget, input int pct, input int drop_at, input bit poke);
    for (int c = 0; c < budget && busy; c++) begin
      y_ready = ($urandom_range(99) < pct);
      start = poke && ($urandom_range(3) == 0);
      if (drop_at >= 0 && dones >= drop_at) continuous = 1'b0;
      tick();
    end
    start = 1'b0;
    check("idle_timeout", {31'b0, busy}, 0);
    y_ready = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; continuous = 1'b0; pattern_sel = 1'b0; y_ready = 1'b0;
    pat_mode = 1'b0; prev_stall = 1'b0; prev_out = '0;
    clear_model();
    for (int j = 0; j < 36; j++) begin
      tbl[j].start = j == 0;
      tbl[j].ready = 1'b1;
      tbl[j].valid = j >= 2 && j <= 33;
      tbl[j].px = tbl[j].valid ? {8'(j - 2), j == 2, ((j - 2) % 8) == 7, j == 33} : 11'b0;
      tbl[j].busy = j <= 33;
      tbl[j].done = j == 34;
      tbl[j].chk_rd = j < 2;
    end
    tick();
    tick();
    check("reset_outs", {16'b0, busy, frame_done, mem_rd_en, y_valid, y_data, y_sof, y_eol, y_eof}, 0);
    rst = 1'b0;
    tick();
    // Latency, throughput and flag placement with y_ready held high.
    clear_model();
    for (int j = 0; j < 36; j++) begin
      start = tbl[j].start;
      y_ready = tbl[j].ready;
      tick();
      start = 1'b0;
      check($sformatf("vec%0d", j),
            {17'b0, y_valid, y_valid ? {y_data, y_sof, y_eol, y_eof} : 11'b0, busy, frame_done, tbl[j].chk_rd & mem_rd_en},
            {17'b0, tbl[j].valid, tbl[j].px, tbl[j].busy, tbl[j].done, tbl[j].chk_rd});
    end
    tick();
    check("vec_pixels", pix, N);
    check("vec_dones", dones, 1);
    // Random backpressure, single frame.
    clear_model();
    start_frame(50);
    run_until_idle(1000, 50, -1, 1'b0);
    check("rand_pixels", pix, N);
    check("rand_dones", dones, 1);
    // Continuous mode, dropped during the third frame.
    clear_model();
    continuous = 1'b1;
    start_frame(70);
    run_until_idle(3000, 70, 2, 1'b0);
    check("cont_pixels", pix, 3 * N);
    check("cont_dones", dones, 3);
    check("cont_idle", {30'b0, busy, y_valid}, 0);
    // Reset in the middle of a frame.
    clear_model();
    y_ready = 1'b1;
    start_frame(100);
    for (int c = 0; c < 100 && pix < 13; c++) tick();
    check("reach_px13", pix, 13);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_abort", {29'b0, y_valid, busy, frame_done}, 0);
    repeat (4) tick();
    check("rst_no_done", dones, 0);
    start_frame(100);
    run_until_idle(1000, 80, -1, 1'b0);
    check("rst_restart_pixels", pix, N);
    check("rst_restart_dones", dones, 1);
    // Start pulses while busy must be ignored.
    clear_model();
    start_frame(60);
    run_until_idle(1000, 60, -1, 1'b1);
    repeat (5) tick();
    check("poke_pixels", pix, N);
    check("poke_dones", dones, 1);
    check("poke_idle", {30'b0, busy, y_valid}, 0);
`ifdef TEST_PATTERN_EN
    // Internal stripe generator; pattern_sel is held internally after the frame starts.
    clear_model();
    pat_mode = 1'b1;
    pattern_sel = 1'b1;
    start_frame(60);
    pattern_sel = 1'b0;
    run_until_idle(1000, 60, -1, 1'b0);
    check("pat_pixels", pix, N);
    check("pat_dones", dones, 1);
    pat_mode = 1'b0;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/pixel_frame_streamer.md
Name: pixel_frame_streamer

Overview:
- Transmit end of the pixel stream that feeds the zebra_crossing_detector x_* input.
- Reads one frame, row-major, from a synchronous-read frame buffer (1-cycle read latency).
- Emits pixels on a valid/ready stream with start-of-frame, end-of-line and end-of-frame flags.
- Sits between the frame buffer (MIF-initialised ROM/RAM) and the pattern-recognition pipeline. Sustains 1 pixel/cycle under backpressure.

Parameters:
IMG_WIDTH, 320, pixels per line
IMG_HEIGHT, 240, lines per frame
W, 8, pixel width in bits
ADDR_W, $clog2(IMG_WIDTH*IMG_HEIGHT), frame-buffer address width (derived)
STRIPE_H, 10, test-pattern stripe height in lines (used only with TEST_PATTERN_EN)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin one frame; sampled only in IDLE
continuous  in  1  on 1, restart automatically after each frame
pattern_sel  in  1  select internal test pattern (TEST_PATTERN_EN only; otherwise ignored)
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse after the eof pixel handshakes
mem_rd_en  out  1  frame-buffer read strobe
mem_addr  out  ADDR_W  frame-buffer read address
mem_rd_data  in  W  read data, valid the cycle after mem_rd_en
y_valid  out  1  output pixel valid
y_ready  in  1  downstream ready
y_data  out  W  pixel value
y_sof  out  1  first pixel of frame (x=0, y=0)
y_eol  out  1  last pixel of a line (x=IMG_WIDTH-1)
y_eof  out  1  last pixel of frame

Behaviour:
- Reset: all outputs 0; FIFO flushed; issue and output counters 0; state IDLE. Reset mid-frame aborts the frame; y_valid is 0 in the cycle after rst is sampled; no frame_done.
- FSM:
  - IDLE -> RUN on start=1; busy=1 from that edge.
  - RUN: issues reads for addresses 0..N-1, N=IMG_WIDTH*IMG_HEIGHT, incrementing by 1. RUN -> DRAIN when address N-1 is issued.
  - DRAIN: when the eof pixel handshakes, frame_done pulses next cycle. Then DRAIN -> RUN (address 0) if continuous=1 in that cycle, else DRAIN -> IDLE.
  - start while busy is ignored.
- Issue rule: mem_rd_en=1 in RUN iff (fifo_count + inflight) < 3. inflight is a 1-bit register. mem_rd_en must not depend combinationally on y_ready.
- Issue-side counters: column x (wraps at IMG_WIDTH-1, then line counter y increments) and linear address. sof/eol/eof flags are computed at issue, delayed one cycle with the read, and written with the data into a 3-deep FIFO.
- Output: y_valid = FIFO non-empty; the FIFO head drives y_data and the flags. Handshake is y_valid & y_ready.
- Once y_valid is high, y_valid, y_data and flags stay stable until the handshake.
- Latency: start sampled at edge t -> mem_rd_en high in cycle t..t+1 -> y_valid high after edge t+2. With y_ready held 1, one pixel per cycle, no bubbles within a frame.
- Continuous mode restarts after the drain; bubbles between frames are allowed.
- Pixel count per frame is exactly N. No pixel is dropped or duplicated under any y_ready pattern.
- Full FIFO with an in-flight read cannot occur, by construction of the issue rule. An assertion checks that no write ever occurs to a full FIFO.

Optional Feature:
- Macro TEST_PATTERN_EN.
- Defined: when pattern_sel=1 (sampled at frame start, held for the frame), mem_rd_en stays 0. Pixel data comes from an internal generator with the same 1-cycle delay: ((y/STRIPE_H) even) ? 8'd250 : 8'd20. Flags and timing are identical to the memory path.
- Undefined: generator absent, pattern_sel ignored, memory path only.

Decomposition:
- Package pixel_stream_pkg:
  - pixel flags struct {sof, eol, eof}
  - FSM state enum {IDLE, RUN, DRAIN}
  - test-pattern constants 250/20
- Sub-module pixel_skid_fifo: 3-deep, W+3 bits wide, with count output, push/pop, and sync clear tied to rst.

Test Plan:
- IMG 8x4, frame buffer = address value, start pulse, y_ready=1 -> y_valid after 2 cycles; data 0..31 on consecutive cycles; sof on 0; eol on 7,15,23,31; eof on 31; frame_done 1 cycle after; busy low afterwards.
- Same setup, y_ready random 50% -> same 32 values in order, no drops or duplicates; y_data stable while y_valid & !y_ready; mem_rd_en never issued with FIFO+inflight=3.
- continuous=1 for 3 frames -> 96 pixels, 3 frame_done pulses, sof on every 32nd pixel; continuous dropped during frame 3 -> IDLE after frame 3.
- rst asserted at pixel 13 -> y_valid=0 next cycle, no frame_done; a new start streams from pixel 0 with sof.
- start pulsed while busy -> ignored; exactly 32 pixels output.
- TEST_PATTERN_EN, STRIPE_H=2, 8x4, pattern_sel=1 -> lines 0-1 =250, lines 2-3 =20; mem_rd_en never high.
